// File: rtl/vend_ctrl_gen_if.sv
// Handshake bundle between the vending front-end/mechanics and vend_ctrl_gen.
// Master drives user, brewer and dispenser inputs; slave is the controller.
interface vend_ctrl_gen_if #(
    parameter int NCOIN = 4,
    parameter int VW    = 16,
    parameter int NPROD = 2
);
    localparam int PW = (NPROD > 1) ? $clog2(NPROD) : 1;

    logic [NCOIN-1:0] coin_in;
    logic             sel_valid;
    logic [PW-1:0]    sel_prod;
    logic [2:0]       sel_cups;
    logic             start;
    logic             ret_req;
    logic             done;
    logic             take_out;
    logic             drop_ack;
    logic [VW-1:0]    credit;
    logic             coin_reject;
    logic             no_funds;
    logic             making;
    logic             coffee;
    logic [NCOIN-1:0] drop;
    logic             busy;

    modport master (
        output coin_in, sel_valid, sel_prod, sel_cups, start, ret_req,
               done, take_out, drop_ack,
        input  credit, coin_reject, no_funds, making, coffee, drop, busy
    );

    modport slave (
        input  coin_in, sel_valid, sel_prod, sel_cups, start, ret_req,
               done, take_out, drop_ack,
        output credit, coin_reject, no_funds, making, coffee, drop, busy
    );
endinterface

// File: rtl/vend_ctrl_gen.sv
// Vending controller: coin credit, per-cup brew loop with per-cup debit,
// greedy largest-first change return with one coin per dispenser handshake.
//  state    | meaning
//  IDLE     | accept coins, selection, start, return request
//  MAKE     | brewer running the current cup
//  TAKE     | cup waiting for removal
//  CHG_SEL  | choose largest coin that fits the credit
//  CHG_DROP | coin eject requested, waiting for drop_ack
module vend_ctrl_gen #(
    parameter int                  NCOIN       = 4,
    parameter int                  VW          = 16,
    parameter logic [NCOIN*VW-1:0] COIN_VALS   = {16'd1000, 16'd500, 16'd100, 16'd50},
    parameter int                  NPROD       = 2,
    parameter logic [NPROD*VW-1:0] PRICES      = {16'd450, 16'd300},
    parameter int                  MAX_CREDIT  = 2000,
    parameter int                  CUPS_MAX    = 5,
    parameter int                  AUTO_CHANGE = 1
) (
    input  logic           CLK,
    input  logic           RST,
    vend_ctrl_gen_if.slave bus
);
    localparam int PW = (NPROD > 1) ? $clog2(NPROD) : 1;
    localparam int CW = (NCOIN > 1) ? $clog2(NCOIN) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MAKE     = 3'd1;
    localparam logic [2:0] S_TAKE     = 3'd2;
    localparam logic [2:0] S_CHG_SEL  = 3'd3;
    localparam logic [2:0] S_CHG_DROP = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [VW-1:0]    credit_q, credit_d;
    logic             sel_ok_q, sel_ok_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [2:0]       cups_q, cups_d;
    logic [2:0]       left_q, left_d;
    logic [CW-1:0]    chg_q, chg_d;
    logic             coin_reject_q, coin_reject_d;
    logic             no_funds_q, no_funds_d;
    logic             making_q, making_d;
    logic             coffee_q, coffee_d;
    logic [NCOIN-1:0] drop_q, drop_d;
    logic             busy_q, busy_d;

    logic [VW-1:0]    coin_val;
    logic [VW:0]      coin_sum;
    logic             coin_fits;
    logic [VW-1:0]    price;
    logic [VW+2:0]    cost;
    logic             funds_ok;
    logic             sel_legal;
    logic [CW-1:0]    pick;
    logic [VW-1:0]    chg_val;

    always_comb begin
        coin_val = '0;
        for (int i = 0; i < NCOIN; i++) begin
            if (bus.coin_in[i]) coin_val = coin_val | COIN_VALS[i*VW +: VW];
        end
        price = '0;
        for (int p = 0; p < NPROD; p++) begin
            if (prod_q == PW'(p)) price = PRICES[p*VW +: VW];
        end
        // Ascending coin table: the last fitting index is the largest coin.
        pick = '0;
        for (int i = 0; i < NCOIN; i++) begin
            if (COIN_VALS[i*VW +: VW] <= credit_q) pick = CW'(i);
        end
    end

    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_fits = (coin_sum <= (VW+1)'(MAX_CREDIT));
    assign cost      = {3'b000, price} * {{VW{1'b0}}, cups_q};
    assign funds_ok  = ({3'b000, credit_q} >= cost);
    assign sel_legal = (int'(bus.sel_prod) < NPROD) && (bus.sel_cups != 3'd0)
                       && (int'(bus.sel_cups) <= CUPS_MAX);
    assign chg_val   = COIN_VALS[chg_q*VW +: VW];

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        sel_ok_d      = sel_ok_q;
        prod_d        = prod_q;
        cups_d        = cups_q;
        left_d        = left_q;
        chg_d         = chg_q;
        no_funds_d    = 1'b0;
        coin_reject_d = (bus.coin_in != '0) && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (bus.coin_in != '0) begin
                    if ($onehot(bus.coin_in) && coin_fits) credit_d = coin_sum[VW-1:0];
                    else                                   coin_reject_d = 1'b1;
                end else if (bus.ret_req) begin
                    if (credit_q != '0) state_d = S_CHG_SEL;
                end else if (bus.start) begin
                    if (sel_ok_q && funds_ok) begin
                        state_d  = S_MAKE;
                        left_d   = cups_q;
                        credit_d = credit_q - price;
                    end else begin
                        no_funds_d = 1'b1;
                    end
                end else if (bus.sel_valid && sel_legal) begin
                    sel_ok_d = 1'b1;
                    prod_d   = bus.sel_prod;
                    cups_d   = bus.sel_cups;
                end
            end
            S_MAKE: begin
                if (bus.done) state_d = S_TAKE;
            end
            S_TAKE: begin
                if (bus.take_out) begin
                    if (left_q > 3'd1) begin
                        left_d   = left_q - 3'd1;
                        credit_d = credit_q - price;
                        state_d  = S_MAKE;
                    end else begin
                        sel_ok_d = 1'b0;
                        prod_d   = '0;
                        cups_d   = '0;
                        left_d   = '0;
                        state_d  = (AUTO_CHANGE != 0 && credit_q != '0) ? S_CHG_SEL : S_IDLE;
                    end
                end
            end
            S_CHG_SEL: begin
                if (credit_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    chg_d   = pick;
                    state_d = S_CHG_DROP;
                end
            end
            S_CHG_DROP: begin
                if (bus.drop_ack) begin
                    credit_d = credit_q - chg_val;
                    state_d  = S_CHG_SEL;
                end
            end
            default: state_d = S_IDLE;
        endcase

        making_d = (state_d == S_MAKE);
        coffee_d = (state_d == S_TAKE);
        busy_d   = (state_d != S_IDLE);
        drop_d   = (state_d == S_CHG_DROP) ? ({{(NCOIN-1){1'b0}}, 1'b1} << chg_d) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            sel_ok_q      <= 1'b0;
            prod_q        <= '0;
            cups_q        <= '0;
            left_q        <= '0;
            chg_q         <= '0;
            coin_reject_q <= 1'b0;
            no_funds_q    <= 1'b0;
            making_q      <= 1'b0;
            coffee_q      <= 1'b0;
            drop_q        <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            sel_ok_q      <= sel_ok_d;
            prod_q        <= prod_d;
            cups_q        <= cups_d;
            left_q        <= left_d;
            chg_q         <= chg_d;
            coin_reject_q <= coin_reject_d;
            no_funds_q    <= no_funds_d;
            making_q      <= making_d;
            coffee_q      <= coffee_d;
            drop_q        <= drop_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.credit      = credit_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.no_funds    = no_funds_q;
    assign bus.making      = making_q;
    assign bus.coffee      = coffee_q;
    assign bus.drop        = drop_q;
    assign bus.busy        = busy_q;
endmodule

// File: doc/vend_ctrl_gen.md
Name: vend_ctrl_gen

Overview:
Parametrised next-generation vending control unit with a built-in data path.
- Accepts NCOIN coin denominations into a credit register.
- Latches a product and cup-count selection, then runs a per-cup make/take-out loop that debits the price of each cup as it starts.
- Returns change greedily, largest coin first, one coin per handshake with the dispenser.
- Sits between the user/coin front-end and the brewer/coin-dispenser mechanics.

Parameters:
- NCOIN, 4, number of coin denominations.
- VW, 16, width of the credit and value arithmetic.
- COIN_VALS, {16'd1000,16'd500,16'd100,16'd50}, packed NCOIN*VW. Index 0 is the smallest coin. Values are strictly ascending, and every value is a multiple of index 0.
- NPROD, 2, number of products.
- PRICES, {16'd450,16'd300}, packed NPROD*VW. Index 0 is product 0. Every price is a multiple of COIN_VALS[0].
- MAX_CREDIT, 2000, upper limit on credit.
- CUPS_MAX, 5, maximum cups per order.
- AUTO_CHANGE, 1, mode select. 1 = enter change return automatically after the last cup. 0 = return to IDLE holding the remaining credit.

Ports:
- CLK, in, 1, clock; all state changes on the rising edge.
- RST, in, 1, synchronous active-high reset.
- coin_in, in, NCOIN, one-cycle pulse, one-hot; bit i means a coin of COIN_VALS[i] was inserted.
- sel_valid, in, 1, pulse; latch sel_prod and sel_cups.
- sel_prod, in, max(1,clog2(NPROD)), product index.
- sel_cups, in, 3, cup count.
- start, in, 1, pulse; request brewing.
- ret_req, in, 1, pulse; request return of all credit.
- done, in, 1, brewer finished the current cup.
- take_out, in, 1, user removed the cup.
- drop_ack, in, 1, dispenser has ejected the requested coin.
- credit, out, VW, current credit.
- coin_reject, out, 1, one-cycle pulse; the coin was not accepted and is physically passed back.
- no_funds, out, 1, one-cycle pulse; start was refused.
- making, out, 1, brewing in progress.
- coffee, out, 1, cup ready for take-out.
- drop, out, NCOIN, one-hot coin eject request.
- busy, out, 1, high in every state except IDLE.

Behaviour:
Reset:
- RST has priority over every other input.
- All outputs are 0, credit is 0, the selection (product and cups) is cleared, and the state is IDLE.
- Reset mid-operation (MAKE, TAKE or CHANGE) abandons the operation immediately; the remaining credit is lost by design.

States: IDLE, MAKE, TAKE, CHG_SEL, CHG_DROP.

IDLE input priority: coin > ret_req > start > sel_valid. Only the highest-priority event present is acted on in a cycle.
- Coin acceptance, 1-cycle latency:
  - If credit + COIN_VALS[i] <= MAX_CREDIT, credit updates at the next edge.
  - Otherwise coin_reject pulses in the next cycle and credit is unchanged.
  - More than one coin_in bit set: coin_reject pulses and no credit is added.
  - coin_in in any state other than IDLE: coin_reject pulses and the coin is ignored.
- sel_valid: latch the selection only if sel_prod < NPROD and 1 <= sel_cups <= CUPS_MAX; otherwise ignore it and keep the previous selection.
- start:
  - Refused if there is no valid selection or credit < PRICES[prod]*cups. no_funds pulses and the state stays IDLE.
  - The cost product is computed at VW+3 bits, with no truncation.
  - If accepted, go to MAKE with cups_left = cups and credit -= price at the same edge.
- ret_req: credit > 0 goes to CHG_SEL; credit == 0 is ignored.

MAKE and TAKE:
- MAKE: making = 1 until done, then go to TAKE.
- TAKE: coffee = 1 until take_out.
  - If cups_left > 1: decrement cups_left, debit the price, go to MAKE.
  - Last cup: clear the selection. Go to CHG_SEL if AUTO_CHANGE = 1 and credit > 0; otherwise go to IDLE.
- done/take_out arriving in any other state are ignored.

Change return:
- CHG_SEL:
  - credit == 0: go to IDLE.
  - Otherwise pick the largest i with COIN_VALS[i] <= credit and go to CHG_DROP.
- CHG_DROP:
  - drop = one-hot i, held stable until drop_ack.
  - On the drop_ack cycle: credit -= COIN_VALS[i], drop = 0, back to CHG_SEL.
  - drop_ack already high on entry is accepted in that same cycle.
- Consequence: minimum 2 cycles per coin; credit never goes negative or wraps.

Output shape:
- making, coffee and drop are registered and decoded from state only.
- drop is never asserted together with making or coffee.

Test Plan:
- Coin accumulation and cap: coin_in = 1000, 500, 500, then 50 → credit reads 1000, 1500, 2000. The 50 raises coin_reject for 1 cycle and credit stays 2000.
- Two-cup order with auto change: credit 1000; select prod 0, cups 2; start → credit 700 and making = 1. Drive done, then take_out → credit 400 and making = 1 again. Drive done, then take_out → drop sequence 100, 100, 100, 100, each held until drop_ack; credit ends 0 and state is IDLE.
- Refused start: credit 600; select prod 1, cups 2 (cost 900); start → no_funds pulse, credit 600, busy stays 0.
- Greedy return with slow acknowledge: credit 1650; ret_req; drop_ack given 3 cycles after each request → drops 1000, 500, 100, 50; each drop is held stable until its ack; credit 0 at the end.
- Illegal inputs: coin_in = 4'b0011 → coin_reject pulses and credit is unchanged. sel_cups = 0 or 6 → selection unchanged. A coin inserted during MAKE → coin_reject.
- Mode and reset: AUTO_CHANGE = 0 with credit 1000 and one cup of prod 0 → IDLE with credit 700. Separately, assert RST during CHG_DROP → drop = 0, credit = 0, IDLE on the next cycle.
